instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the single-cycle ARMv8 datapath. Owns the program counter, drives the byte address into the instruction memory and captures the 32-bit word it returns. Buffers fetched words with their PC in a small FIFO and delivers them to decode over a valid/ready handshake. Accepts branch redirects from the execute/branch logic.

## Interface
- RESET_PC, 64'h038: PC value loaded on reset; the first fetch address.
- PC_LIMIT, 64'h06C: first address not fetched; reaching it halts fetch.
- BUF_DEPTH, 2: FIFO entries, power of two, 2..8.
- Clock  in  1  sole clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Address  out  64  byte address to instruction memory; equals PC combinationally.
- Instruction  in  32  word from instruction memory for Address, valid in the same cycle.
- InstrOut  out  32  FIFO head instruction; 0 when Valid=0.
- PCOut  out  64  PC of the FIFO head; 0 when Valid=0.
- Valid  out  1  FIFO non-empty.
- Ready  in  1  decode accepts the head when Valid&Ready at a rising edge.
- BranchTaken  in  1  redirect request, sampled at the rising edge.
- BranchTarget  in  64  redirect address.
- Halted  out  1  PC reached PC_LIMIT; fetch stopped.
- Fault  out  1  misaligned redirect; see Configuration.

## Operation
- State: PC, FIFO storage of {PC, Instruction} entries, read/write pointers, occupancy count (clog2(BUF_DEPTH)+1 bits), Halted, Fault.
- Reset values: PC=RESET_PC, count=0, Valid=0, InstrOut=0, PCOut=0, Halted=0, Fault=0.
- Fetch enable: fetch = !Halted && !Fault && (count<BUF_DEPTH || pop).
- Pop: pop = Valid && Ready.
- On a fetch edge, {PC, Instruction} is written at the write pointer and PC <= PC+4. PC arithmetic is 64-bit and wraps modulo 2^64.
- Pop advances the read pointer. Pointers wrap at BUF_DEPTH.
- Push and pop in the same cycle leave count unchanged. A push into a full FIFO is allowed only with a simultaneous pop.
- Redirect takes priority over all other actions. In the BranchTaken cycle:
  - FIFO is flushed (count=0, pointers=0) and no push occurs.
  - Any pop in that cycle still counts as accepted by decode.
  - PC <= BranchTarget and Halted <= 0.
- Halt: Halted <= 1 when the PC register equals PC_LIMIT. While Halted, Address holds PC_LIMIT and nothing is pushed. Already-buffered entries still drain normally.
- Order: entries are delivered strictly in fetch order. No entry is duplicated or dropped except by a flush.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. Buffered entries are discarded.

## Timing
- Address is combinational from PC; there is zero cycles from a PC update to a new Address.
- Fetch-to-decode latency is 1 cycle. A word fetched at edge N is on InstrOut/PCOut with Valid=1 after edge N, when the FIFO was empty.
- After reset release, the first rising edge captures RESET_PC, so Valid rises after the first edge.
- After a redirect edge, Address=BranchTarget in the same cycle. Valid with PCOut=BranchTarget follows after the next edge.
- Throughput is 1 instruction per cycle with Ready held high.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with BranchTarget[1:0]!=0 sets Fault=1, flushes the FIFO and leaves PC unchanged.
  - Fault is sticky until reset and blocks fetch.
- FETCH_ALIGN_CHECK_EN undefined:
  - BranchTarget[1:0] is ignored and treated as 00.
  - Fault is tied to 0.

## Test plan
- Reset release with a memory model, Ready=1 → Address=0x038. After edge 1: Valid=1, PCOut=0x038, InstrOut=32'h8B1F03E9. After edge 2: PCOut=0x03C, InstrOut=32'hB2048D29.
- Ready=0 for 5 cycles after reset → count saturates at 2 and Address holds 0x040. After Ready=1, heads are 0x038, 0x03C, 0x040 in order with no repeats.
- FIFO full, BranchTaken=1 with target 0x05C → next cycle Valid=0 and Address=0x05C. After one more edge: PCOut=0x05C, InstrOut=32'hB237BD29.
- Run straight to PC_LIMIT → last delivered PCOut=0x068 (32'hF84283EA), then Halted=1, Valid=0, Address=0x06C. A redirect to 0x038 clears Halted.
- Reset_n pulsed low mid-cycle with 2 entries buffered → immediate Valid=0, Halted=0, Address=0x038, and the sequence restarts at 0x038.
- FETCH_ALIGN_CHECK_EN defined, redirect to 0x062 → Fault=1, Valid=0, fetch frozen. Undefined, the same redirect → PCOut=0x060 and Fault=0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch-stage bus: instruction memory port, decode handshake, redirect and status
interface instruction_fetch_if;
    logic [63:0] address;
    logic [31:0] instruction;
    logic [31:0] instr_out;
    logic [63:0] pc_out;
    logic        valid;
    logic        ready;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        halted;
    logic        fault;

    modport master (
        output address, instr_out, pc_out, valid, halted, fault,
        input  instruction, ready, branch_taken, branch_target
    );

    modport slave (
        input  address, instr_out, pc_out, valid, halted, fault,
        output instruction, ready, branch_taken, branch_target
    );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner, instruction fetch and decode FIFO with redirect/halt
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect raises a sticky fault instead of masking the target.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h038,
    parameter logic [63:0] PC_LIMIT  = 64'h06C,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    instruction_fetch_if.master bus
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    logic [63:0]      r_pc;
    logic [63:0]      r_buf_pc    [BUF_DEPTH];
    logic [31:0]      r_buf_instr [BUF_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_halted;
    logic             r_fault;

    logic             w_valid;
    logic             w_pop;
    logic             w_fetch;
    logic             w_push;
    logic             w_misaligned;
    logic [63:0]      w_target;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misaligned = (bus.branch_target[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif
    assign w_target = bus.branch_target & ~64'h3;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && bus.ready;
    // PC_LIMIT itself is never fetched, even in the cycle before Halted registers
    assign w_fetch = !r_halted && !r_fault && (r_pc != PC_LIMIT) && ((r_count < FULL) || w_pop);
    assign w_push  = w_fetch && !bus.branch_taken;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc     <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else if (bus.branch_taken) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
            if (w_misaligned) begin
                r_fault <= 1'b1;
            end else begin
                r_pc <= w_target;
            end
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + 64'd4;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (r_pc == PC_LIMIT) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is visible
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]    <= r_pc;
            r_buf_instr[r_wr_ptr] <= bus.instruction;
        end
    end

    assign bus.address   = r_pc;
    assign bus.valid     = w_valid;
    assign bus.pc_out    = w_valid ? r_buf_pc[r_rd_ptr] : 64'd0;
    assign bus.instr_out = w_valid ? r_buf_instr[r_rd_ptr] : 32'd0;
    assign bus.halted    = r_halted;
    assign bus.fault     = r_fault;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - table-driven check of instruction_fetch with an instruction ROM model
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    instruction_fetch_if bus_if();

    instruction_fetch #(
        .RESET_PC (64'h038),
        .PC_LIMIT (64'h06C),
        .BUF_DEPTH(2)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus_if.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [63:0] a);
        case (a)
            64'h038: rom = 32'h8B1F03E9;
            64'h03C: rom = 32'hB2048D29;
            64'h05C: rom = 32'hB237BD29;
            64'h068: rom = 32'hF84283EA;
            default: rom = {16'hE000, a[15:0]};
        endcase
    endfunction

    assign bus_if.instruction = rom(bus_if.address);

    typedef struct {
        logic        ready;
        logic        br;
        logic [63:0] tgt;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [63:0] e_addr;
        logic        e_halted;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_valid, input logic [63:0] e_pc,
                           input logic [63:0] e_addr, input logic e_halted, input logic e_fault);
        chk({tag, ".valid"},  64'(bus_if.valid),  64'(e_valid));
        chk({tag, ".pc_out"}, bus_if.pc_out,      e_valid ? e_pc : 64'd0);
        chk({tag, ".instr"},  64'(bus_if.instr_out), e_valid ? 64'(rom(e_pc)) : 64'd0);
        chk({tag, ".addr"},   bus_if.address,     e_addr);
        chk({tag, ".halted"}, 64'(bus_if.halted), 64'(e_halted));
        chk({tag, ".fault"},  64'(bus_if.fault),  64'(e_fault));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h038, 64'h03C, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h03C, 64'h040, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h03C, 64'h044, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h03C, 64'h044, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h03C, 64'h044, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h040, 64'h048, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h044, 64'h04C, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h044, 64'h04C, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 64'h05C, 1'b0, 64'h0,   64'h05C, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h05C, 64'h060, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h060, 64'h064, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h064, 64'h068, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h068, 64'h06C, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 64'h0,   1'b0, 64'h0,   64'h06C, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 64'h0,   1'b0, 64'h0,   64'h06C, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 64'h038, 1'b0, 64'h0,   64'h038, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h038, 64'h03C, 1'b0};

        bus_if.ready         = 1'b0;
        bus_if.branch_taken  = 1'b0;
        bus_if.branch_target = 64'h0;

        #12;
        chk_all("reset", 1'b0, 64'h0, 64'h038, 1'b0, 1'b0);
        rst_n = 1'b1;
        bus_if.ready = 1'b1;
        chk("reset.addr_release", bus_if.address, 64'h038);

        for (int i = 0; i < 17; i++) begin
            bus_if.ready         = vecs[i].ready;
            bus_if.branch_taken  = vecs[i].br;
            bus_if.branch_target = vecs[i].tgt;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_addr,
                    vecs[i].e_halted, 1'b0);
        end
        bus_if.branch_taken = 1'b0;

        // Two entries buffered, then an asynchronous reset pulse mid-cycle
        bus_if.ready = 1'b0;
        step();
        chk_all("prefill", 1'b1, 64'h038, 64'h040, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 64'h0, 64'h038, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            step();
            chk_all($sformatf("stall%0d", k), 1'b1, 64'h038, (k == 0) ? 64'h03C : 64'h040, 1'b0, 1'b0);
        end
        bus_if.ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all($sformatf("drain%0d", k), 1'b1, 64'h03C + 64'(4 * k), 64'h044 + 64'(4 * k), 1'b0, 1'b0);
        end

        // Misaligned redirect: PC currently 0x04C
        bus_if.branch_taken  = 1'b1;
        bus_if.branch_target = 64'h062;
        step();
        bus_if.branch_taken = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk_all("misalign", 1'b0, 64'h0, 64'h04C, 1'b0, 1'b1);
        step();
        chk_all("frozen0", 1'b0, 64'h0, 64'h04C, 1'b0, 1'b1);
        step();
        chk_all("frozen1", 1'b0, 64'h0, 64'h04C, 1'b0, 1'b1);
`else
        chk_all("misalign", 1'b0, 64'h0, 64'h060, 1'b0, 1'b0);
        step();
        chk_all("masked0", 1'b1, 64'h060, 64'h064, 1'b0, 1'b0);
        step();
        chk_all("masked1", 1'b1, 64'h064, 64'h068, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
